alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_if.sv | 34 +++
 rtl/alu_exec.sv | 144 ++++++++++++++
 tb/tb_alu_exec.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_if.sv
// ============================================================================
// Module  : alu_exec_if
// Valid/ready operand and result bus for the alu_exec execute stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       operation;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, operation, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal, busy
  );

  modport slave (
    input  in_valid, operation, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal, busy
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec.sv
// ============================================================================
// Module  : alu_exec
// Registered ALU execute stage with a one-entry result register and valid/ready
// handshake. Define ALU_MULT_EN to add op 1000 (iterative unsigned multiply).
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_exec #(
  parameter int WIDTH = 32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  alu_exec_if.slave   bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_hold = 2'd1;
  localparam logic [1:0] c_st_mul  = 2'd2;

  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_or  = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_slt = 4'b0111;
  localparam logic [3:0] c_op_nor = 4'b1100;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic             w_in_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_res;
  logic             w_illegal;

`ifdef ALU_MULT_EN
  localparam logic [3:0] c_op_mul = 4'b1000;
  localparam int         CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
`endif

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      c_st_idle: w_in_ready = 1'b1;
      c_st_hold: w_in_ready = bus.out_ready;
      default:   w_in_ready = 1'b0;
    endcase
  end

  assign w_xfer = bus.in_valid & w_in_ready;

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (bus.operation)
      c_op_and: w_res = bus.a & bus.b;
      c_op_or:  w_res = bus.a | bus.b;
      c_op_add: w_res = bus.a + bus.b;
      c_op_sub: w_res = bus.a - bus.b;
      c_op_slt: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      c_op_nor: w_res = ~(bus.a | bus.b);
`ifdef ALU_MULT_EN
      c_op_mul: w_res = '0;
`endif
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_st_idle;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef ALU_MULT_EN
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
`endif
    end else if (w_xfer) begin
`ifdef ALU_MULT_EN
      if (bus.operation == c_op_mul) begin
        r_state  <= c_st_mul;
        r_cnt    <= '0;
        r_mcand  <= bus.a;
        r_mplier <= bus.b;
        r_acc    <= '0;
      end else
`endif
      begin
        r_state   <= c_st_hold;
        r_result  <= w_res;
        r_zero    <= (w_res == '0);
        r_illegal <= w_illegal;
      end
    end else if (r_state == c_st_hold) begin
      if (bus.out_ready) begin
        r_state <= c_st_idle;
      end
`ifdef ALU_MULT_EN
    end else if (r_state == c_st_mul) begin
      // One partial product per cycle; the extra cycle at c_cnt_last commits it.
      if (r_cnt == c_cnt_last) begin
        r_state   <= c_st_hold;
        r_result  <= r_acc;
        r_zero    <= (r_acc == '0);
        r_illegal <= 1'b0;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end
`endif
    end else if (r_state != c_st_idle) begin
      r_state <= c_st_idle;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == c_st_hold);
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.illegal   = r_illegal;
`ifdef ALU_MULT_EN
  assign bus.busy      = (r_state == c_st_mul);
`else
  assign bus.busy      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_exec.sv
// ============================================================================
// Module  : tb_alu_exec
// Self-checking bench for alu_exec with directed cases and a randomized
// scoreboard run; multiply cases compile in with ALU_MULT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_exec_if #(.WIDTH(W)) bus ();

  alu_exec #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU from the opcode table; SLT decided from sign bits first.
  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] r,
                                  output logic ill);
    logic lt;
    ill = 1'b0;
    r   = '0;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd6:  r = x - y;
      4'd7:  begin
        if (x[W-1] != y[W-1]) lt = x[W-1];
        else                  lt = (x < y);
        r = lt ? 1 : 0;
      end
      4'd12: r = ~(x | y);
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic ordy);
    bus.in_valid  = v;
    bus.operation = op;
    bus.a         = x;
    bus.b         = y;
    bus.out_ready = ordy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'd0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== '0 ||
        bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b busy=%b res=%h z=%b ill=%b exp 0 0 0 0 0",
               bus.out_valid, bus.busy, bus.result, bus.zero, bus.illegal);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 4'b0010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1 ||
        bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap got v=%b res=%h z=%b ill=%b exp 1 0 1 0",
               bus.out_valid, bus.result, bus.zero, bus.illegal);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain got out_valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_slt();
    drive(1'b1, 4'b0111, 32'h8000_0000, 32'd0, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd1 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL slt_neg got v=%b res=%h z=%b exp 1 1 0", bus.out_valid, bus.result, bus.zero);
    end
    drive(1'b1, 4'b0111, 32'd0, 32'h8000_0000, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL slt_pos got v=%b res=%h z=%b exp 1 0 1", bus.out_valid, bus.result, bus.zero);
    end
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 4'b0110, 32'd5, 32'd3, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'b0);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd2 || bus.in_ready !== 1'b0 ||
          bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b res=%h rdy=%b ill=%b exp 1 2 0 0",
                 k, bus.out_valid, bus.result, bus.in_ready, bus.illegal);
      end
      tick();
    end
    drive(1'b1, 4'b0000, 32'hF0, 32'h3C, 1'b1);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h30 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL bp_b2b got v=%b res=%h z=%b exp 1 30 0", bus.out_valid, bus.result, bus.zero);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got out_valid=%b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 4'b0101, 32'h1234, 32'h5678, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== '0 || bus.zero !== 1'b1 ||
        bus.illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_0101 got v=%b res=%h z=%b ill=%b exp 1 0 1 1",
               bus.out_valid, bus.result, bus.zero, bus.illegal);
    end
`ifndef ALU_MULT_EN
    drive(1'b1, 4'b1000, 32'd7, 32'd9, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== '0 || bus.zero !== 1'b1 ||
        bus.illegal !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_1000 got v=%b res=%h z=%b ill=%b busy=%b exp 1 0 1 1 0",
               bus.out_valid, bus.result, bus.zero, bus.illegal, bus.busy);
    end
`endif
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_hold();
    drive(1'b1, 4'b0010, 32'd40, 32'd2, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold got v=%b res=%h z=%b exp 0 0 0", bus.out_valid, bus.result, bus.zero);
    end
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_release got v=%b rdy=%b exp 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

`ifdef ALU_MULT_EN
  task automatic test_mult();
    bit bad;
    drive(1'b1, 4'b1000, 32'd1234, 32'd5678, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    bad = 1'b0;
    for (int k = 1; k <= W + 1; k++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        if (!bad) $display("FAIL mul_busy edge=%0d got busy=%b rdy=%b v=%b exp 1 0 0",
                           k - 1, bus.busy, bus.in_ready, bus.out_valid);
        bad = 1'b1;
      end
      tick();
    end
    checks++;
    if (bad) errors++;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 32'd7006652 ||
        bus.illegal !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL mul_result got v=%b busy=%b res=%0d ill=%b z=%b exp 1 0 7006652 0 0",
               bus.out_valid, bus.busy, bus.result, bus.illegal, bus.zero);
    end
    tick();
  endtask

  task automatic test_reset_mid_mult();
    bit bad;
    drive(1'b1, 4'b1000, 32'd99, 32'd77, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_rst got v=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
    end
    #2;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < W + 8; k++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mul_rst_after got late output after reset exp none");
    end
  endtask
`endif

  // Randomized traffic against a one-entry scoreboard of the expected result.
  task automatic test_random();
    logic           exp_v;
    logic [W-1:0]   exp_r, r;
    logic           exp_i, ill, exp_rdy, v, ordy;
    logic [3:0]     op;
    logic [W-1:0]   x, y;
    logic [3:0]     legal [6];
    legal = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    exp_v = 1'b0;
    exp_r = '0;
    exp_i = 1'b0;
    for (int n = 0; n < 300; n++) begin
      v    = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      op   = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      if (op == 4'd8) op = 4'd2;
      x = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? x : W'($urandom);
      drive(v, op, x, y, ordy);
      #1;
      exp_rdy = !exp_v || ordy;
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rnd_in_ready n=%0d got %b exp %b", n, bus.in_ready, exp_rdy);
      end
      if (v && exp_rdy) begin
        ref_alu(op, x, y, r, ill);
        exp_v = 1'b1;
        exp_r = r;
        exp_i = ill;
      end else if (exp_v && ordy) begin
        exp_v = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== exp_v ||
          (exp_v && (bus.result !== exp_r || bus.zero !== (exp_r == '0) || bus.illegal !== exp_i))) begin
        errors++;
        $display("FAIL rnd_out n=%0d got v=%b res=%h z=%b ill=%b exp v=%b res=%h z=%b ill=%b",
                 n, bus.out_valid, bus.result, bus.zero, bus.illegal,
                 exp_v, exp_r, (exp_r == '0), exp_i);
      end
    end
    drive(1'b0, 4'd0, '0, '0, 1'b1);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_slt();
    test_backpressure();
    test_illegal();
    test_reset_in_hold();
`ifdef ALU_MULT_EN
    test_mult();
    test_reset_mid_mult();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
